mand_solver_hs: RTL
===================

Name: mand_solver_hs

Overview:
- Parametrised successor of the single-point Mandelbrot escape-time solver.
- Iterates z(n+1) = z(n)^2 + c in signed fixed point, with configurable integer/fraction widths and a runtime iteration limit.
- Uses a valid/ready handshake on input and output, and carries a caller tag through with each point.
- Sits between the pixel/coordinate generator and the colour-map/frame-buffer writer; several instances can be tiled behind an arbiter.

Parameters:
INT_BITS, 7, integer bits including sign of every fixed-point operand.
FRAC_BITS, 20, fraction bits; W = INT_BITS+FRAC_BITS (27 by default).
ITER_W, 16, width of the iteration limit and result count.
TAG_W, 8, width of the opaque tag passed from input to output.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  c_re/c_im/max_iter/in_tag valid.
in_ready  out  1  block can accept a point this cycle.
c_re  in  W  real part of c, signed Q(INT_BITS).(FRAC_BITS).
c_im  in  W  imaginary part of c, same format.
max_iter  in  ITER_W  iteration limit for this point.
in_tag  in  TAG_W  opaque tag.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_iter  out  ITER_W  iterations completed before escape, or max_iter on convergence.
out_diverged  out  1  1 = escaped, 0 = hit limit.
out_tag  out  TAG_W  tag of the point.

Behaviour:
- Reset (clock and reset as named; sync, active-high):
  - state=IDLE; out_valid=0, out_iter=0, out_diverged=0, out_tag=0; internal z and n cleared.
  - Reset mid-RUN or mid-DONE abandons the point; no result is emitted.
- FSM IDLE -> RUN -> DONE -> IDLE (or DONE -> RUN directly).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no dependence on in_valid.
- Accept (in_valid && in_ready):
  - Latch c, max_iter, in_tag.
  - z_re<=c_re, z_im<=c_im, n<=0; state<=RUN.
  - If acceptance happens in DONE, the old result retires in the same edge.
- Each RUN cycle, in priority order:
  - 1) if n >= max_iter_latched: done, diverged=0, count=max_iter.
  - 2) else if |z|^2 > 4.0: done, diverged=1, count=n.
  - 3) else z<=z^2+c, n<=n+1.
  - When done: state<=DONE, out_valid<=1, and out_* are loaded on that edge.
- Latency: point accepted at edge T, decided in RUN cycle T+1+k (k = final n). out_valid is high from cycle T+2+k.
- DONE: out_* held stable while out_valid && !out_ready. Retire on out_ready; go to IDLE, or to RUN if a new point is accepted in the same cycle.
- Arithmetic:
  - Products are full 2W-bit signed, truncated to bits [W+FRAC_BITS-1:FRAC_BITS]. Truncation is toward -inf, no rounding.
  - re' = z_re^2 - z_im^2 + c_re; im' = 2*z_re*z_im + c_im. The doubling is an arithmetic left shift, and sums wrap at W bits.
  - |z|^2 = z_re^2 + z_im^2 is computed at W+1 bits, so it cannot wrap. It is compared signed-greater-than against 4<<FRAC_BITS; equality does not escape.
  - Valid input domain is |c_re|,|c_im| <= 2.0. Outside this domain count is still correct only if |c|^2 > 4 (escapes at n=0).
- max_iter=0: result is converged, count 0, at T+2, even if |c| > 2.
- in_valid while busy and not ready: ignored; the upstream holds it.

Optional Feature:
MAND_SOLVER_BULB_CHECK_EN
- Defined:
  - At acceptance, compute (c_re+1)^2 + c_im^2 with the same multiplier format.
  - If the result < 1/16 (strictly) and max_iter > 0, the first RUN cycle finishes with diverged=0, count=max_iter. Latency is always 2.
  - All other points are unchanged.
- Undefined: no bulb logic. Bulb points iterate to max_iter. Results are bit-identical either way; only latency differs.

Test Plan:
- c=1.0+0j (c_re=0x100000), max_iter=100, tag=0x5A -> out_diverged=1, out_iter=2, out_tag=0x5A, out_valid exactly at T+4.
- c=3.0+0j (0x300000), max_iter=100 -> diverged=1, iter=0 at T+2. Same c with max_iter=0 -> diverged=0, iter=0 at T+2.
- c=-2.0+0j, max_iter=50 -> |z|^2 stays exactly 4.0, no escape; diverged=0, iter=50 at T+52.
- Hold out_ready=0 for 10 cycles after out_valid -> out_* stable and in_ready=0 throughout. Then raise out_ready together with in_valid (c=0, max_iter=3) -> old result retires, new point accepted the same edge, next out_valid 5 cycles later with iter=3.
- Assert reset during RUN of c=0, max_iter=1000 -> next cycle out_valid=0, in_ready=1, and no stale result appears afterward.
- c=-1.0+0j, max_iter=200 -> with MAND_SOLVER_BULB_CHECK_EN: diverged=0, iter=200 at T+2; without the macro: the same values at T+202.

Source files
------------

// File: rtl/mand_solver_hs.sv
// mand_solver_hs: Mandelbrot escape-time solver, one point in flight, valid/ready on both sides.
// Latency: point accepted at edge T gives out_valid from cycle T+2+k (k = final n), or T+2 on a bulb hit.
// Backpressure: the result is held in DONE until out_ready; a new point is taken in IDLE or in DONE with out_ready.
// Optional: define MAND_SOLVER_BULB_CHECK_EN to finish points inside the period-2 bulb on the first RUN cycle.
module mand_solver_hs #(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 20,
  parameter int ITER_W    = 16,
  parameter int TAG_W     = 8,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_diverged,
  output logic [TAG_W-1:0]    out_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Escape threshold 4.0; |z|^2 lives at W+1 bits so the compare never sees a wrapped sum.
  localparam logic signed [W:0] ESC_LIMIT = (W+1)'(64'sd4 <<< FRAC_BITS);

  state_t              state_q;
  logic signed [W-1:0] z_re_q, z_im_q;
  logic signed [W-1:0] c_re_q, c_im_q;
  logic [ITER_W-1:0]   n_q, max_iter_q;
  logic [TAG_W-1:0]    tag_q;

  logic                out_valid_q;
  logic                out_div_q;
  logic [ITER_W-1:0]   out_iter_q;
  logic [TAG_W-1:0]    out_tag_q;

  // Iteration datapath signals
  logic signed [2*W-1:0] p_rr, p_ii, p_ri;
  logic signed [W-1:0]   sq_re, sq_im, x_ri;
  logic signed [W:0]     mag;
  logic signed [W-1:0]   z_re_d, z_im_d;
  logic [ITER_W-1:0]     n_d;
  logic                  escape;
  logic                  limit_hit;
  logic                  accept;

  // Handshake: a slot is free when idle, or when the held result retires this very cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // One iteration step: full-width products truncated toward -inf back to Q(INT).(FRAC).
  always_comb begin
    p_rr      = (2*W)'(z_re_q) * (2*W)'(z_re_q);
    p_ii      = (2*W)'(z_im_q) * (2*W)'(z_im_q);
    p_ri      = (2*W)'(z_re_q) * (2*W)'(z_im_q);
    sq_re     = W'(p_rr >>> FRAC_BITS);
    sq_im     = W'(p_ii >>> FRAC_BITS);
    x_ri      = W'(p_ri >>> FRAC_BITS);
    mag       = (W+1)'(sq_re) + (W+1)'(sq_im);
    escape    = mag > ESC_LIMIT;
    // The cross term is doubled after truncation; both sums wrap at W bits.
    z_re_d    = sq_re - sq_im + c_re_q;
    z_im_d    = (x_ri <<< 1) + c_im_q;
    n_d       = n_q + ITER_W'(1);
    limit_hit = n_q >= max_iter_q;
  end

`ifdef MAND_SOLVER_BULB_CHECK_EN
  // Points with (c_re+1)^2 + c_im^2 < 1/16 sit in the period-2 bulb and never escape.
  localparam logic signed [W-1:0] ONE        = W'(64'sd1 <<< FRAC_BITS);
  localparam logic signed [W:0]   BULB_LIMIT = (W+1)'(64'sd1 <<< (FRAC_BITS - 4));

  logic signed [W-1:0]   b_re, b_sq_re, b_sq_im;
  logic signed [2*W-1:0] p_bre, p_bim;
  logic signed [W:0]     b_mag;
  logic                  bulb_hit;
  logic                  bulb_q;

  // Bulb test on the incoming c, evaluated in the accept cycle with the iteration's number format.
  always_comb begin
    b_re     = c_re + ONE;
    p_bre    = (2*W)'(b_re) * (2*W)'(b_re);
    p_bim    = (2*W)'(c_im) * (2*W)'(c_im);
    b_sq_re  = W'(p_bre >>> FRAC_BITS);
    b_sq_im  = W'(p_bim >>> FRAC_BITS);
    b_mag    = (W+1)'(b_sq_re) + (W+1)'(b_sq_im);
    bulb_hit = (b_mag < BULB_LIMIT) && (max_iter != '0);
  end
`endif

  // Control FSM with registered result outputs; accept is applied last so DONE->RUN wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      z_re_q      <= '0;
      z_im_q      <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      n_q         <= '0;
      max_iter_q  <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_div_q   <= 1'b0;
      out_iter_q  <= '0;
      out_tag_q   <= '0;
`ifdef MAND_SOLVER_BULB_CHECK_EN
      bulb_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (limit_hit) begin
            // Limit reached first: converged, report the limit itself.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_div_q   <= 1'b0;
            out_iter_q  <= max_iter_q;
            out_tag_q   <= tag_q;
          end
`ifdef MAND_SOLVER_BULB_CHECK_EN
          else if (bulb_q) begin
            // Known non-escaping point: report convergence without iterating.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_div_q   <= 1'b0;
            out_iter_q  <= max_iter_q;
            out_tag_q   <= tag_q;
          end
`endif
          else if (escape) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_div_q   <= 1'b1;
            out_iter_q  <= n_q;
            out_tag_q   <= tag_q;
          end else begin
            z_re_q <= z_re_d;
            z_im_q <= z_im_d;
            n_q    <= n_d;
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
        end
      endcase

      if (accept) begin
        state_q    <= RUN;
        c_re_q     <= c_re;
        c_im_q     <= c_im;
        z_re_q     <= c_re;
        z_im_q     <= c_im;
        n_q        <= '0;
        max_iter_q <= max_iter;
        tag_q      <= in_tag;
`ifdef MAND_SOLVER_BULB_CHECK_EN
        bulb_q     <= bulb_hit;
`endif
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_diverged = out_div_q;
  assign out_iter     = out_iter_q;
  assign out_tag      = out_tag_q;

endmodule
